// File: rtl/sobel_edge_if.sv
// Pixel stream bundle for the Sobel edge stage: windowed gray input with
// sideband on the way in, edge pixel with delay-matched sideband on the way out.
interface sobel_edge_if #(
  parameter int COLORDEPTH = 8
);
  logic [COLORDEPTH-1:0] vect_in_0;
  logic [COLORDEPTH-1:0] vect_in_1;
  logic [COLORDEPTH-1:0] vect_in_2;
  logic                  dv_i;
  logic                  hs_i;
  logic                  vs_i;
  logic                  line_end_i;
  logic [COLORDEPTH-1:0] thresh_i;
  logic                  mode_i;
  logic [COLORDEPTH-1:0] edge_o;
  logic                  dv_o;
  logic                  hs_o;
  logic                  vs_o;
  logic                  line_end_o;

  modport master (
    output vect_in_0, vect_in_1, vect_in_2, dv_i, hs_i, vs_i, line_end_i,
           thresh_i, mode_i,
    input  edge_o, dv_o, hs_o, vs_o, line_end_o
  );

  modport slave (
    input  vect_in_0, vect_in_1, vect_in_2, dv_i, hs_i, vs_i, line_end_i,
           thresh_i, mode_i,
    output edge_o, dv_o, hs_o, vs_o, line_end_o
  );
endinterface

// File: rtl/sobel_edge.sv
// Sobel edge stage: 3x3 window over three buffered lines, |Gx|+|Gy| magnitude,
// saturated or thresholded output, 4-cycle delay-matched sideband.
module sobel_edge #(
  parameter int COLORDEPTH  = 8,
  parameter int SCREENWIDTH = 1600
) (
  input  logic         clk,
  input  logic         rst,
  sobel_edge_if.slave  bus
);

  if (COLORDEPTH != 8 || SCREENWIDTH < 3) begin : g_cfg_check
    $error("sobel_edge: only COLORDEPTH=8 and SCREENWIDTH>=3 are supported");
  end

  // win[r][c]: row 0 = oldest line, column 2 = newest pixel
  logic [2:0][2:0][7:0] win;
  logic [2:0][7:0]      col_in;
  logic [1:0]           col_cnt;
  logic                 vs_prev;
  logic                 vs_rise;
  logic [7:0]           thr_q;
  logic                 win_valid;
  logic                 valid2;
  logic                 valid3;
  logic signed [10:0]   gx_q;
  logic signed [10:0]   gy_q;
  logic [10:0]          sum_q;
  logic [7:0]           edge_q;
  logic [7:0]           edge_nxt;
  logic [9:0]           gx_p, gx_n, gy_p, gy_n;
  logic [10:0]          gx_abs, gy_abs;
  logic [3:0]           dv_d, hs_d, vs_d, le_d;

  always_comb begin
    col_in  = {bus.vect_in_2, bus.vect_in_1, bus.vect_in_0};
    vs_rise = bus.vs_i & ~vs_prev;
  end

  always_comb begin
    gx_p = 10'(win[0][2]) + 10'({win[1][2], 1'b0}) + 10'(win[2][2]);
    gx_n = 10'(win[0][0]) + 10'({win[1][0], 1'b0}) + 10'(win[2][0]);
    gy_p = 10'(win[2][0]) + 10'({win[2][1], 1'b0}) + 10'(win[2][2]);
    gy_n = 10'(win[0][0]) + 10'({win[0][1], 1'b0}) + 10'(win[0][2]);
  end

  always_comb begin
    gx_abs = gx_q[10] ? 11'(-gx_q) : gx_q;
    gy_abs = gy_q[10] ? 11'(-gy_q) : gy_q;
  end

  // Invalid windows and blanking cycles both produce a black pixel
  always_comb begin
    edge_nxt = '0;
    if (dv_d[2] && valid3) begin
      if (bus.mode_i)
        edge_nxt = (sum_q >= {3'b000, thr_q}) ? 8'hFF : 8'h00;
      else
        edge_nxt = (sum_q > 11'd255) ? 8'hFF : sum_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win       <= '0;
      col_cnt   <= '0;
      vs_prev   <= 1'b0;
      thr_q     <= 8'd128;
      win_valid <= 1'b0;
    end else begin
      vs_prev <= bus.vs_i;
      if (vs_rise)
        thr_q <= bus.thresh_i;
      if (bus.line_end_i || vs_rise)
        col_cnt <= '0;
      else if (bus.dv_i && col_cnt != 2'd3)
        col_cnt <= col_cnt + 2'd1;
      win_valid <= bus.dv_i && (col_cnt >= 2'd2);
      if (bus.dv_i) begin
        win[0] <= {col_in[0], win[0][2], win[0][1]};
        win[1] <= {col_in[1], win[1][2], win[1][1]};
        win[2] <= {col_in[2], win[2][2], win[2][1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx_q   <= '0;
      gy_q   <= '0;
      valid2 <= 1'b0;
      sum_q  <= '0;
      valid3 <= 1'b0;
      edge_q <= '0;
      dv_d   <= '0;
      hs_d   <= '0;
      vs_d   <= '0;
      le_d   <= '0;
    end else begin
      gx_q   <= $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
      gy_q   <= $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
      valid2 <= win_valid;
      sum_q  <= gx_abs + gy_abs;
      valid3 <= valid2;
      edge_q <= edge_nxt;
      dv_d   <= {dv_d[2:0], bus.dv_i};
      hs_d   <= {hs_d[2:0], bus.hs_i};
      vs_d   <= {vs_d[2:0], bus.vs_i};
      le_d   <= {le_d[2:0], bus.line_end_i};
    end
  end

  assign bus.edge_o     = edge_q;
  assign bus.dv_o       = dv_d[3];
  assign bus.hs_o       = hs_d[3];
  assign bus.vs_o       = vs_d[3];
  assign bus.line_end_o = le_d[3];

endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge: directed patterns plus random frames checked
// against an arithmetic 3x3 Sobel reference model.
module tb_sobel_edge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_edge_if #(.COLORDEPTH(8)) bus ();

  sobel_edge #(.COLORDEPTH(8), .SCREENWIDTH(1600)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned due;
    bit          dv, hs, vs, le, valid;
    int          sum;
    int          thr;
  } rec_t;

  rec_t        sb[$];
  rec_t        mr;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_e;

  // Reference model state: pixel columns seen, columns counted on this line
  int m_win[3][3];
  int m_cols;
  bit m_vs_prev;
  int m_thr;
  int cur_thresh;
  bit cur_mode;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) m_win[r][c] = 0;
    m_cols    = 0;
    m_vs_prev = 1'b0;
    m_thr     = 128;
  endtask

  task automatic apply(input int a, input int b, input int c,
                       input bit dv, input bit hs, input bit vs, input bit le);
    rec_t r;
    bit   rise;
    int   gx, gy;
    bus.vect_in_0  = 8'(a);
    bus.vect_in_1  = 8'(b);
    bus.vect_in_2  = 8'(c);
    bus.dv_i       = dv;
    bus.hs_i       = hs;
    bus.vs_i       = vs;
    bus.line_end_i = le;
    bus.thresh_i   = 8'(cur_thresh);
    bus.mode_i     = cur_mode;
    rise    = vs && !m_vs_prev;
    r.valid = dv && (m_cols >= 2);
    if (dv) begin
      for (int i = 0; i < 3; i++) begin
        m_win[i][0] = m_win[i][1];
        m_win[i][1] = m_win[i][2];
      end
      m_win[0][2] = a;
      m_win[1][2] = b;
      m_win[2][2] = c;
    end
    if (le || rise) m_cols = 0;
    else if (dv)    m_cols++;
    if (rise) m_thr = cur_thresh;
    m_vs_prev = vs;
    gx = (m_win[0][2] + 2*m_win[1][2] + m_win[2][2]) - (m_win[0][0] + 2*m_win[1][0] + m_win[2][0]);
    gy = (m_win[2][0] + 2*m_win[2][1] + m_win[2][2]) - (m_win[0][0] + 2*m_win[0][1] + m_win[0][2]);
    r.sum = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    r.thr = m_thr;
    r.dv  = dv;
    r.hs  = hs;
    r.vs  = vs;
    r.le  = le;
    r.due = cyc + 4;
    sb.push_back(r);
  endtask

  task automatic drive(input int a, input int b, input int c,
                       input bit dv, input bit hs, input bit vs, input bit le);
    @(negedge clk);
    #2;
    apply(a, b, c, dv, hs, vs, le);
  endtask

  task automatic pix(input int a, input int b, input int c);
    drive(a, b, c, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(0, 0, 0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic lend();
    drive(0, 0, 0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
  endtask

  // Quiet gap lets in-flight pixels leave before the threshold can change
  task automatic frame_start(input int th);
    repeat (5) idle();
    cur_thresh = th;
    drive(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) idle();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_edge_o"}, int'(bus.edge_o), 0);
    chk({tag, "_dv_o"}, int'(bus.dv_o), 0);
    chk({tag, "_hs_o"}, int'(bus.hs_o), 0);
    chk({tag, "_vs_o"}, int'(bus.vs_o), 0);
    chk({tag, "_line_end_o"}, int'(bus.line_end_o), 0);
  endtask

  task automatic do_reset(input int cycles_low);
    @(negedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk_outputs_zero("reset_async");
    for (int i = 0; i < cycles_low; i++) begin
      @(negedge clk);
      #2;
      bus.dv_i      = 1'b1;
      bus.vect_in_0 = 8'($urandom_range(0, 255));
      bus.vect_in_1 = 8'($urandom_range(0, 255));
      bus.vect_in_2 = 8'($urandom_range(0, 255));
      chk_outputs_zero("reset_hold");
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    apply(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic line150();
    pix(0, 0, 0);
    pix(0, 0, 0);
    repeat (3) pix(37, 38, 37);
    lend();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        mr = sb.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL stale_record: due %0d now %0d", mr.due, cyc);
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        mr = sb.pop_front();
        exp_e = 0;
        if (mr.valid && mr.dv)
          exp_e = bus.mode_i ? ((mr.sum >= mr.thr) ? 255 : 0)
                             : ((mr.sum > 255) ? 255 : mr.sum);
        chk("edge_o", int'(bus.edge_o), exp_e);
        chk("dv_o", int'(bus.dv_o), int'(mr.dv));
        chk("hs_o", int'(bus.hs_o), int'(mr.hs));
        chk("vs_o", int'(bus.vs_o), int'(mr.vs));
        chk("line_end_o", int'(bus.line_end_o), int'(mr.le));
      end else begin
        chk_outputs_zero("post_reset");
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int amp, n;
    rst        = 1'b0;
    cur_thresh = 128;
    cur_mode   = 1'b0;
    model_reset();
    bus.vect_in_0 = '0; bus.vect_in_1 = '0; bus.vect_in_2 = '0;
    bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0; bus.line_end_i = 1'b0;
    bus.thresh_i = 8'd128; bus.mode_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("initial_reset");
    #2;
    rst = 1'b1;
    apply(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flat field
    frame_start(128);
    repeat (20) pix(100, 100, 100);
    lend();

    // Ramp, magnitude then binary at two thresholds
    pix(0, 0, 0); pix(10, 10, 10); pix(20, 20, 20); lend();
    cur_mode = 1'b1;
    pix(0, 0, 0); pix(10, 10, 10); pix(20, 20, 20); lend();
    frame_start(80);
    pix(0, 0, 0); pix(10, 10, 10); pix(20, 20, 20); lend();

    // Vertical and horizontal steps
    cur_mode = 1'b0;
    pix(0, 0, 0); pix(0, 0, 0);
    repeat (4) pix(255, 255, 255);
    lend();
    repeat (4) pix(0, 0, 255);
    lend();

    // Step at line start
    pix(255, 255, 255); pix(255, 255, 255);
    repeat (3) pix(0, 0, 0);
    lend();

    // Threshold only follows vs rising edges
    cur_mode = 1'b1;
    frame_start(200);
    line150();
    cur_thresh = 100;
    line150();
    frame_start(100);
    line150();

    // Reset mid-line while step edges are in flight; thr returns to 128
    frame_start(200);
    cur_mode = 1'b0;
    pix(0, 0, 0); pix(0, 0, 0);
    repeat (4) pix(255, 255, 255);
    do_reset(3);
    cur_mode = 1'b1;
    line150();
    pix(0, 0, 0); pix(10, 10, 10); pix(20, 20, 20); lend();

    // Random frames, dv gaps, per-cycle mode, occasional line_end with dv
    for (int f = 0; f < 4; f++) begin
      frame_start(int'($urandom_range(0, 255)));
      for (int l = 0; l < 5; l++) begin
        amp = int'($urandom_range(0, 255));
        n   = int'($urandom_range(4, 30));
        for (int i = 0; i < n; i++) begin
          cur_mode = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 4) == 0) idle();
          else pix(int'($urandom_range(0, amp)), int'($urandom_range(0, amp)),
                   int'($urandom_range(0, amp)));
        end
        if ($urandom_range(0, 3) == 0)
          drive(int'($urandom_range(0, amp)), int'($urandom_range(0, amp)),
                int'($urandom_range(0, amp)), 1'b1, 1'b0, 1'b0, 1'b1);
        else
          lend();
      end
    end

    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
